// File: rtl/zigzag_serializer.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_serializer
// Brief    : Double-buffered 8x8 block collector; emits one coefficient per
//            cycle in JPEG zigzag order. Optional macro ZIGZAG_BYPASS_EN adds
//            zz_bypass for raster-order readout.
// Revision : 1.0 - initial release
// ============================================================================
module zigzag_serializer #(
  parameter int QW = 15
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic signed [7:0][QW-1:0]   d,
  input  logic [2:0]                  d_cnt,
  input  logic                        d_valid,
  output logic                        d_hold,
`ifdef ZIGZAG_BYPASS_EN
  input  logic                        zz_bypass,
`endif
  output logic signed [QW-1:0]        q,
  output logic [5:0]                  q_idx,
  output logic                        q_last,
  output logic                        q_valid,
  input  logic                        q_hold
);

  // Scan index -> natural address (row*8 + col)
  localparam logic [5:0] c_zz [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [QW-1:0] r_mem [2][64];
  logic [1:0]    r_full;
  logic          r_wptr;
  logic          r_rptr;
  logic [5:0]    r_rd_idx;

  logic          w_accept;
  logic          w_wr_done;
  logic          w_rd_go;
  logic          w_rd_done;
  logic [5:0]    w_raddr;

  assign d_hold    = r_full[r_wptr];
  assign w_accept  = d_valid & ~d_hold;
  assign w_wr_done = w_accept & (d_cnt == 3'd7);
  assign w_rd_go   = ~q_hold & r_full[r_rptr];
  assign w_rd_done = w_rd_go & (r_rd_idx == 6'd63);

`ifdef ZIGZAG_BYPASS_EN
  logic r_byp;
  logic w_byp;

  // Mode is taken live on the first load and latched for the rest of the block
  assign w_byp   = (r_rd_idx == 6'd0) ? zz_bypass : r_byp;
  assign w_raddr = w_byp ? r_rd_idx : c_zz[r_rd_idx];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_byp <= 1'b0;
    end else if (w_rd_go && (r_rd_idx == 6'd0)) begin
      r_byp <= zz_bypass;
    end
  end
`else
  assign w_raddr = c_zz[r_rd_idx];
`endif

  // Bank storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (resetn && w_accept) begin
      for (int c = 0; c < 8; c++) begin
        r_mem[r_wptr][{d_cnt, 3'(c)}] <= d[c];
      end
    end
  end

  // Set and clear can never target the same bank on one edge
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_full   <= 2'b00;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_rd_idx <= 6'd0;
    end else begin
      if (w_wr_done) begin
        r_full[r_wptr] <= 1'b1;
        r_wptr         <= ~r_wptr;
      end
      if (w_rd_done) begin
        r_full[r_rptr] <= 1'b0;
        r_rptr         <= ~r_rptr;
      end
      if (w_rd_go) begin
        r_rd_idx <= r_rd_idx + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q       <= '0;
      q_idx   <= 6'd0;
      q_last  <= 1'b0;
      q_valid <= 1'b0;
    end else if (!q_hold) begin
      q_valid <= r_full[r_rptr];
      if (r_full[r_rptr]) begin
        q      <= r_mem[r_rptr][w_raddr];
        q_idx  <= r_rd_idx;
        q_last <= (r_rd_idx == 6'd63);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zigzag_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_zigzag_serializer
// Brief    : Scoreboard bench for zigzag_serializer (bypass tests under
//            ZIGZAG_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_zigzag_serializer;
  localparam int QW = 15;

  localparam int ZZ [64] = '{
     0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
    12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
    35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
    58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63
  };

  logic                      clk = 1'b0;
  logic                      resetn = 1'b0;
  logic signed [7:0][QW-1:0] d = '0;
  logic [2:0]                d_cnt = 3'd0;
  logic                      d_valid = 1'b0;
  logic                      d_hold;
  logic signed [QW-1:0]      q;
  logic [5:0]                q_idx;
  logic                      q_last;
  logic                      q_valid;
  logic                      q_hold = 1'b0;
`ifdef ZIGZAG_BYPASS_EN
  logic                      zz_bypass = 1'b0;
`endif

  zigzag_serializer #(.QW(QW)) dut (
    .clk(clk), .resetn(resetn), .d(d), .d_cnt(d_cnt), .d_valid(d_valid),
    .d_hold(d_hold),
`ifdef ZIGZAG_BYPASS_EN
    .zz_bypass(zz_bypass),
`endif
    .q(q), .q_idx(q_idx), .q_last(q_last), .q_valid(q_valid), .q_hold(q_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [QW-1:0] q;
    logic [5:0]    idx;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [QW-1:0] m_bank [2][64];
  int            m_wptr = 0;
  bit            exp_raster = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_out = 0;
  int            last_cyc[$];
  int            acc_cyc = 0;
  logic          first_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every consumed output (valid and not stalled) is popped and compared
  always @(negedge clk) begin
    if (resetn && q_valid && !q_hold) begin
      checks++;
      n_out++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected: got q=%0h idx=%0d last=%0b, expected no output", q, q_idx, q_last);
      end else begin
        mon_e = sb.pop_front();
        if (q !== mon_e.q || q_idx !== mon_e.idx || q_last !== mon_e.last) begin
          errors++;
          $display("FAIL stream: got q=%0h idx=%0d last=%0b, expected q=%0h idx=%0d last=%0b",
                   q, q_idx, q_last, mon_e.q, mon_e.idx, mon_e.last);
        end
      end
      if (q_last) last_cyc.push_back(cyc);
    end
  end

  function automatic logic [7:0][QW-1:0] mk_row(input int base, input int row);
    logic [7:0][QW-1:0] r;
    for (int c = 0; c < 8; c++) r[c] = QW'(base + 8 * row + c);
    return r;
  endfunction

  function automatic logic [7:0][QW-1:0] rand_row();
    logic [7:0][QW-1:0] r;
    for (int c = 0; c < 8; c++) r[c] = QW'($urandom);
    return r;
  endfunction

  task automatic push_block();
    int a;
    for (int k = 0; k < 64; k++) begin
      a = exp_raster ? k : ZZ[k];
      sb.push_back('{m_bank[m_wptr][a], 6'(k), (k == 63)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send_row(input int row, input logic [7:0][QW-1:0] vals);
    int  tmo = 0;
    bit  first = 1'b1;
    d_valid = 1'b1;
    d_cnt   = 3'(row);
    d       = vals;
    forever begin
      @(negedge clk);
      if (first) first_hold = d_hold;
      first = 1'b0;
      if (!d_hold) break;
      tmo++;
      if (tmo > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: row %0d still held after %0d cycles, expected acceptance", row, tmo);
        d_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc + 1;
    for (int c = 0; c < 8; c++) m_bank[m_wptr][row * 8 + c] = vals[c];
    if (row == 7) begin
      push_block();
      m_wptr ^= 1;
    end
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 400) begin @(posedge clk); #1; t++; end
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle(3);
    @(negedge clk);
    checks += 5;
    if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid: got %b expected 0", q_valid); end
    if (q !== '0)         begin errors++; $display("FAIL reset_q: got %0h expected 0", q); end
    if (q_idx !== 6'd0)   begin errors++; $display("FAIL reset_q_idx: got %0d expected 0", q_idx); end
    if (q_last !== 1'b0)  begin errors++; $display("FAIL reset_q_last: got %b expected 0", q_last); end
    if (d_hold !== 1'b0)  begin errors++; $display("FAIL reset_d_hold: got %b expected 0", d_hold); end
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(1);
  endtask

  task automatic test_single_block();
    int cnt = 0;
    int n0 = n_out;
    exp_raster = 1'b0;
    for (int r = 0; r < 8; r++) send_row(r, mk_row(0, r));
    @(negedge clk);
    checks++;
    if (q_valid !== 1'b0) begin errors++; $display("FAIL latency_early: q_valid %b one negedge after row7 edge, expected 0", q_valid); end
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (q_valid) cnt++;
      else if (cnt > 0) break;
    end
    checks += 2;
    if (cnt != 64) begin errors++; $display("FAIL single_valid_run: got %0d consecutive valid cycles, expected 64", cnt); end
    if (n_out - n0 != 64) begin errors++; $display("FAIL single_count: got %0d outputs, expected 64", n_out - n0); end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    int n0 = n_out;
    int l0 = last_cyc.size();
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < 8; r++) begin
        send_row(r, mk_row(100 * (b + 1), r));
        if (b == 2 && r == 0) begin
          checks += 2;
          if (first_hold !== 1'b1) begin errors++; $display("FAIL b2b_d_hold: block3 row0 first saw d_hold=%b, expected 1", first_hold); end
          if (last_cyc.size() <= l0 || acc_cyc != last_cyc[l0] + 1) begin
            errors++;
            $display("FAIL b2b_block3_accept: accepted cycle %0d, expected one after block1 q_last", acc_cyc);
          end
        end
      end
    end
    wait_drain("b2b");
    checks++;
    if (n_out - n0 != 192) begin errors++; $display("FAIL b2b_count: got %0d outputs, expected 192", n_out - n0); end
  endtask

  task automatic test_hold();
    int n0 = n_out;
    bit prev_h = 1'b0;
    logic [QW-1:0] s_q;
    logic [5:0] s_idx;
    logic s_last, s_valid;
    for (int r = 0; r < 8; r++) send_row(r, rand_row());
    for (int i = 0; i < 400 && (sb.size() != 0 || i < 4); i++) begin
      @(posedge clk); #1;
      if (prev_h && s_valid) begin
        checks++;
        if (q !== s_q || q_idx !== s_idx || q_last !== s_last || q_valid !== 1'b1) begin
          errors++;
          $display("FAIL hold_stable: got q=%0h idx=%0d, expected q=%0h idx=%0d frozen", q, q_idx, s_q, s_idx);
        end
      end
      q_hold = ~q_hold;
      @(negedge clk);
      prev_h = q_hold; s_q = q; s_idx = q_idx; s_last = q_last; s_valid = q_valid;
    end
    @(posedge clk); #1;
    q_hold = 1'b0;
    wait_drain("hold");
    checks++;
    if (n_out - n0 != 64) begin errors++; $display("FAIL hold_count: got %0d outputs, expected 64", n_out - n0); end
  endtask

  task automatic test_gaps();
    for (int r = 7; r >= 0; r--) begin
      send_row(r, mk_row(700, r));
      idle($urandom_range(0, 3));
    end
    for (int r = 0; r < 8; r++) begin
      send_row(r, rand_row());
      idle($urandom_range(0, 3));
    end
    wait_drain("gaps");
  endtask

  task automatic test_mid_reset();
    int t = 0;
    for (int r = 0; r < 8; r++) send_row(r, mk_row(900, r));
    do begin @(negedge clk); t++; end while (!(q_valid && q_idx == 6'd19) && t < 200);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    sb.delete();
    m_wptr = 0;
    @(negedge clk);
    checks += 2;
    if (q_valid !== 1'b0) begin errors++; $display("FAIL midreset_q_valid: got %b expected 0", q_valid); end
    if (d_hold !== 1'b0)  begin errors++; $display("FAIL midreset_d_hold: got %b expected 0", d_hold); end
    @(posedge clk); #1;
    for (int r = 0; r < 8; r++) send_row(r, mk_row(1000, r));
    wait_drain("midreset");
  endtask

`ifdef ZIGZAG_BYPASS_EN
  task automatic test_bypass();
    int t = 0;
    exp_raster = 1'b1;
    zz_bypass  = 1'b1;
    for (int r = 0; r < 8; r++) send_row(r, mk_row(0, r));
    do begin @(negedge clk); t++; end while (!(q_valid && q_idx == 6'd10) && t < 200);
    zz_bypass = 1'b0;
    wait_drain("bypass");
    exp_raster = 1'b0;
    for (int r = 0; r < 8; r++) send_row(r, mk_row(50, r));
    wait_drain("bypass_next");
  endtask
`endif

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_hold();
    test_gaps();
    test_mid_reset();
`ifdef ZIGZAG_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zigzag_serializer.md
Name: zigzag_serializer

Overview:
- Consumer of the 8-wide vector stream produced by the JPEG encoder's transpose stage.
- Collects eight vectors of QW-bit signed coefficients into one 8x8 block.
- Emits the block one coefficient per cycle in JPEG zigzag order, tagged with a scan index and a last flag, toward quantisation and entropy coding.
- Double-buffered so one block can be written while the previous one drains.

Parameters:
QW, 15, coefficient width in bits, signed (matches the second-pass transpose width)

Ports:
clk  input  1  clock, all logic single-clock on rising edge
resetn  input  1  reset, synchronous, active-low
d  input  8 x QW signed  vector elements; d[i] = column i of row d_cnt
d_cnt  input  3  row index of the current vector
d_valid  input  1  vector present
d_hold  output  1  back-pressure to upstream; vector accepted when d_valid & ~d_hold
q  output  QW signed  serial coefficient
q_idx  output  6  zigzag scan index of q, 0..63
q_last  output  1  high with q_idx == 63
q_valid  output  1  q, q_idx, q_last valid
q_hold  input  1  downstream stall; freezes all output registers and the read side

Behaviour:
- Storage: 2 banks x 64 entries x QW, flop array. Entry address = row*8 + col. Per-bank full flag; 1-bit wptr and rptr.
- Write side:
  - d_hold = full[wptr], combinational.
  - On acceptance, all 8 elements are written to bank wptr at rows d_cnt, columns 0..7 in one cycle.
  - Accepting d_cnt == 7 sets full[wptr] and toggles wptr on the same edge.
  - d_cnt is trusted. Rows may arrive in any order; a row written twice keeps the last value. Completion is triggered only by row 7.
- Read side, when q_hold == 1: nothing on the read side changes, whatever the value of q_valid.
- Read side, when q_hold == 0:
  - If full[rptr]: load q <= bank[rptr][ZZ[rd_idx]], q_idx <= rd_idx, q_last <= (rd_idx == 63), q_valid <= 1, then rd_idx++.
  - On the rd_idx == 63 load: clear full[rptr], toggle rptr, wrap rd_idx to 0.
  - Otherwise: q_valid <= 0. q, q_idx and q_last keep their values.
- Latency: q_valid rises on the first edge after the edge that accepted the row-7 vector, given q_hold == 0. A full bank then streams 64 consecutive cycles with no bubbles. Back-to-back full banks stream continuously.
- Throughput limits: write 8 cycles per block, read 64 cycles per block. Upstream therefore sees d_hold for about 56 of every 64 cycles in steady state.
- Simultaneous events:
  - Freeing a bank and writing row-7 of the other bank on the same edge are independent.
  - The bank being freed is visible to the write side (d_hold low) on the following cycle.
  - Data is already in the output register when its bank is freed, so there is no hazard.
- ZZ table (scan index -> natural address): 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- Reset values: q_valid 0, q 0, q_idx 0, q_last 0, d_hold 0, full flags 0, wptr/rptr 0, rd_idx 0. Bank contents are not reset.
- Reset mid-operation discards both banks and any partial block. The next accepted vectors start a fresh block in bank 0.

Optional Feature:
- Macro: ZIGZAG_BYPASS_EN.
- When defined:
  - Adds input port zz_bypass (1 bit).
  - zz_bypass is sampled when rd_idx == 0 is loaded and holds for that whole block.
  - If 1, the block is read in raster order (address = rd_idx). q_idx still counts 0..63.
- When undefined: no port; zigzag order always.

Test Plan:
- Single block, d[i] = 8*row + i, rows 0..7 back-to-back, q_hold = 0:
  - q sequence 0,1,8,16,9,2,3,10,...,62,63.
  - q_idx 0..63; q_last only on the 64th output.
  - q_valid first high one cycle after row-7 acceptance and stays high for 64 cycles.
- Three blocks presented continuously, q_hold = 0:
  - d_hold rises after block 2 completes.
  - Block 3 row 0 is accepted the cycle after block 1's q_last.
  - 192 outputs, none lost or duplicated.
- q_hold toggling 1/0 each cycle during readout:
  - Outputs stay stable while held.
  - Exactly 64 distinct q_idx values in order.
- Rows written in order 7,6,...,0 with d_valid gaps:
  - The block is considered complete after row 7, which arrives first.
  - Output contents therefore reflect row 7 plus stale data for other rows.
  - Rows written in order 0..7 with random gaps give the correct zigzag stream.
- resetn pulsed low while q_idx = 20:
  - Next cycle q_valid = 0, d_hold = 0.
  - A subsequent block streams correctly from q_idx 0.
- With ZIGZAG_BYPASS_EN and zz_bypass = 1, same data as the first scenario:
  - q = 0,1,2,...,63.
  - zz_bypass toggled mid-block has no effect until the next block.
